// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/request and result/status bundle between the issuer and alu_seq
interface alu_seq_if #(
  parameter int WIDTH     = 8,
  parameter int PC_WIDTH  = 6,
  parameter int IMM_WIDTH = 6
);
  logic                 start;
  logic [2:0]           op;
  logic                 use_imm;
  logic [IMM_WIDTH-1:0] imm;
  logic [PC_WIDTH-1:0]  pc;
  logic [WIDTH-1:0]     src1;
  logic [WIDTH-1:0]     src2;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;
  logic [2:0]           nzp;
  logic                 illegal;
  modport master (output start, op, use_imm, imm, pc, src1, src2,
                  input  busy, done, result, nzp, illegal);
  modport slave  (input  start, op, use_imm, imm, pc, src1, src2,
                  output busy, done, result, nzp, illegal);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU (add/and/not/lea/shifts/shift-add mul) with registered result, nzp and illegal flag
module alu_seq #(
  parameter int WIDTH     = 8,
  parameter int PC_WIDTH  = 6,
  parameter int IMM_WIDTH = 6
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
  state_t               state_q, state_d;
  logic [SW-1:0]        cnt_q;
  logic [2:0]           op_q;
  logic                 use_imm_q;
  logic [IMM_WIDTH-1:0] imm_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [WIDTH-1:0]     a_q, b_q, acc_q, result_q;
  logic [2:0]           nzp_q;
  logic                 illegal_q;
  logic [WIDTH-1:0]     exec_res, mul_sum, res_d;
  logic [PC_WIDTH-1:0]  lea;
  logic                 accept, fin;
  always_comb begin
    accept  = state_q == IDLE && bus.start;
    state_d = state_q == IDLE ? (bus.start ? (bus.op == 3'b110 ? MUL : EXEC) : IDLE) :
              state_q == EXEC ? DONE :
              state_q == MUL  ? (cnt_q == '0 ? DONE : MUL) : IDLE;
    fin     = state_q == EXEC || (state_q == MUL && cnt_q == '0);
    mul_sum = acc_q + (b_q[0] ? a_q : '0);
    lea     = pc_q + PC_WIDTH'(imm_q);
    case (op_q)
      3'b000:  exec_res = a_q + b_q;
      3'b001:  exec_res = a_q & b_q;
      3'b010:  exec_res = use_imm_q ? ~b_q : ~a_q;
      3'b011:  exec_res = WIDTH'(lea);
      3'b100:  exec_res = a_q << b_q[SW-1:0];
      3'b101:  exec_res = a_q >> b_q[SW-1:0];
      default: exec_res = '0;
    endcase
    res_d = state_q == MUL ? mul_sum : exec_res;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      pc_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      nzp_q     <= 3'b010;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= bus.op;
        use_imm_q <= bus.use_imm;
        imm_q     <= bus.imm;
        pc_q      <= bus.pc;
        a_q       <= bus.src1;
        b_q       <= bus.use_imm ? WIDTH'(bus.imm) : bus.src2;
        acc_q     <= '0;
        cnt_q     <= SW'(WIDTH - 1);
      end
      // one partial product per cycle: multiplicand walks left, multiplier bits consumed from the LSB
      if (state_q == MUL) begin
        acc_q <= mul_sum;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
      if (fin) begin
        result_q  <= res_d;
        nzp_q     <= {res_d[WIDTH-1], res_d == '0, !res_d[WIDTH-1] && res_d != '0};
        illegal_q <= state_q == EXEC && op_q == 3'b111;
      end
    end
  end
  assign bus.busy    = state_q == EXEC || state_q == MUL;
  assign bus.done    = state_q == DONE;
  assign bus.result  = result_q;
  assign bus.nzp     = nzp_q;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq
module tb_alu_seq;
  localparam int W = 8, PW = 6, IW = 6;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  alu_seq_if #(.WIDTH(W), .PC_WIDTH(PW), .IMM_WIDTH(IW)) bus();
  alu_seq #(.WIDTH(W), .PC_WIDTH(PW), .IMM_WIDTH(IW)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {logic [W-1:0] res; logic [2:0] nzp; logic ill;} exp_t;
  exp_t sb[$];
  exp_t e;
  int compared = 0, mismatched = 0, dones = 0, d0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst && bus.done) begin
    dones++;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL unexpected_done: result 0x%0h with no pending expectation", bus.result);
    end else begin
      e = sb.pop_front();
      chk("result", bus.result, e.res);
      chk("nzp", bus.nzp, e.nzp);
      chk("illegal", bus.illegal, e.ill);
    end
  end
  task automatic issue(input logic [2:0] op, input logic ui, input logic [IW-1:0] imm,
                       input logic [PW-1:0] pc, input logic [W-1:0] s1, input logic [W-1:0] s2,
                       input logic [W-1:0] er, input logic [2:0] en, input logic ei);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.use_imm = ui; bus.imm = imm;
    bus.pc = pc; bus.src1 = s1; bus.src2 = s2;
    @(posedge clk);
    sb.push_back(exp_t'{er, en, ei});
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_done(input string name, input int lat, input int hold, input bit done_start);
    int n = 0, b = 0;
    bit got = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      bus.start = (i <= hold);
      b += int'(bus.busy);
      @(posedge clk); #1;
      if (bus.done) begin got = 1; n = i; end
    end
    bus.start = 1'b0;
    chk({name, "_latency"}, n, lat);
    chk({name, "_busy_cycles"}, b, lat);
    chk({name, "_busy_at_done"}, bus.busy, 0);
    if (got) begin
      bus.start = done_start;
      bus.op = 3'b000;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.start = 0; bus.op = 0; bus.use_imm = 0; bus.imm = 0; bus.pc = 0; bus.src1 = 0; bus.src2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0); chk("rst_done", bus.done, 0); chk("rst_result", bus.result, 0);
    chk("rst_nzp", bus.nzp, 3'b010); chk("rst_illegal", bus.illegal, 0);
    @(negedge clk) rst = 1'b0;
    issue(3'b000, 0, 0, 0, 8'h7F, 8'h01, 8'h80, 3'b100, 0); wait_done("add", 1, 0, 0);
    issue(3'b110, 0, 0, 0, 8'd13, 8'd11, 8'h8F, 3'b100, 0); wait_done("mul13x11", 8, 0, 0);
    issue(3'b110, 0, 0, 0, 8'd16, 8'd16, 8'h00, 3'b010, 0); wait_done("mul16x16", 8, 0, 0);
    issue(3'b011, 0, 6'h05, 6'h3E, 8'hAA, 8'hAA, 8'h03, 3'b001, 0); wait_done("lea", 1, 0, 0);
    issue(3'b010, 1, 6'h05, 0, 8'h33, 8'h00, 8'hFA, 3'b100, 0); wait_done("not_imm", 1, 0, 0);
    issue(3'b110, 0, 0, 0, 8'd7, 8'd9, 8'h3F, 3'b001, 0);
    bus.op = 3'b000; bus.src1 = 8'hFF; bus.src2 = 8'hFF; bus.use_imm = 1; bus.imm = 6'h3F;
    d0 = dones;
    wait_done("mul_ignore", 8, 3, 1);
    repeat (4) @(posedge clk);
    #1 chk("ignored_start_done_count", dones - d0, 1);
    issue(3'b100, 0, 0, 0, 8'h03, 8'h0A, 8'h0C, 3'b001, 0); wait_done("shl", 1, 0, 0);
    issue(3'b101, 1, 6'h07, 0, 8'h80, 8'hFF, 8'h01, 3'b001, 0); wait_done("shr_imm", 1, 0, 0);
    issue(3'b100, 0, 0, 0, 8'h55, 8'h08, 8'h55, 3'b001, 0); wait_done("shl_zero", 1, 0, 0);
    issue(3'b000, 1, 6'h02, 0, 8'hFE, 8'h77, 8'h00, 3'b010, 0); wait_done("add_wrap", 1, 0, 0);
    issue(3'b111, 0, 0, 0, 8'h12, 8'h34, 8'h00, 3'b010, 1); wait_done("reserved", 1, 0, 0);
    issue(3'b001, 0, 0, 0, 8'hF0, 8'h3C, 8'h30, 3'b001, 0); wait_done("and", 1, 0, 0);
    issue(3'b111, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b010, 1); wait_done("reserved2", 1, 0, 0);
    issue(3'b110, 0, 0, 0, 8'd5, 8'd5, 8'h19, 3'b001, 0);
    d0 = dones;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 sb.delete();
    chk("abort_busy", bus.busy, 0); chk("abort_done", bus.done, 0); chk("abort_result", bus.result, 0);
    chk("abort_nzp", bus.nzp, 3'b010); chk("abort_illegal", bus.illegal, 0);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("abort_no_done", dones - d0, 0);
    issue(3'b000, 0, 0, 0, 8'd3, 8'd4, 8'h07, 3'b001, 0); wait_done("add_after_rst", 1, 0, 0);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the datapath ALU. It executes register/immediate arithmetic, logic, shift, address and iterative-multiply operations. Operands are captured on a start handshake, and the result is registered with a done pulse. A signed N/Z/P condition-code register is updated on every completed operation. It sits between the register file read ports and the writeback/branch-condition logic, and lets the control FSM stall on `busy` for multi-cycle operations.

## Interface
Parameters:
- `WIDTH`, 8, datapath width in bits (≥4, power of two).
- `PC_WIDTH`, 6, program-counter width (≤ WIDTH).
- `IMM_WIDTH`, 6, instruction immediate field width (≤ WIDTH).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  000 ADD, 001 AND, 010 NOT, 011 LEA, 100 SHL, 101 SHR, 110 MUL, 111 reserved.
- `use_imm`  in  1  second operand = zero-extended `imm` instead of `src2`.
- `imm`  in  IMM_WIDTH  instruction immediate.
- `pc`  in  PC_WIDTH  current program counter.
- `src1`  in  WIDTH  register operand 1.
- `src2`  in  WIDTH  register operand 2.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse; `result`/`nzp` valid from this cycle.
- `result`  out  WIDTH  registered result; holds until the next done.
- `nzp`  out  3  {negative, zero, positive}, exactly one bit set.
- `illegal`  out  1  registered; high with done when op = 111, cleared on the next done.

## Operation
- Operand B = `use_imm` ? {zeros, imm} : `src2`. All operand, op and `pc` values are latched at start acceptance; later input changes have no effect.
- ADD: A + B, truncated to WIDTH, no carry out.
- AND: A & B.
- NOT: `use_imm` ? ~B : ~A.
- LEA: zero-extend((pc + imm[PC_WIDTH-1:0]) mod 2^PC_WIDTH). Uses `imm`, ignores `use_imm`.
- SHL / SHR: logical shift of A by B[log2(WIDTH)-1:0]. A shift of 0 passes A through.
- MUL: low WIDTH bits of A × B. Shift-add, one partial product per cycle, WIDTH iterations.
- Reserved op 111: result = 0, nzp = 010, illegal = 1.
- nzp uses the signed interpretation of result:
  - N = result[WIDTH-1];
  - Z = (result == 0);
  - P = !N && !Z.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE → EXEC on start with op ≠ 110.
  - IDLE → MUL on start with op = 110 (iteration counter loaded with WIDTH-1).
  - EXEC → DONE.
  - MUL → MUL while counter ≠ 0, decrementing each cycle.
  - MUL → DONE when counter = 0.
  - DONE → IDLE unconditionally.
- `start` outside IDLE is ignored and not queued. This includes `start` during DONE.
- Reset values: state IDLE, busy 0, done 0, result 0, nzp 010, illegal 0, counter 0.
- Reset asserted mid-operation aborts it. No done is produced and outputs take their reset values immediately.

## Timing
- Start accepted at edge t (IDLE, start = 1).
- Single-cycle ops: busy is high for cycle t..t+1. result, nzp and done are registered at edge t+1, and done is high for cycle t+1..t+2. Latency is 1 cycle; back-to-back issue is possible every 3 cycles.
- MUL: busy is high from edge t until edge t+WIDTH. result, nzp and done are registered at edge t+WIDTH. Latency is WIDTH cycles (8 at default).
- busy and done are never high in the same cycle.
- Earliest next accepted start is at edge t+latency+2 (state DONE returns to IDLE at edge t+latency+1).
- result and nzp change only at a done edge or reset.

## Test plan
- Reset mid-stream, then ADD, use_imm = 0, src1 = 0x7F, src2 = 0x01 → done 1 cycle after accept; result = 0x80; nzp = 100; busy high for exactly one cycle.
- MUL src1 = 13, src2 = 11 (WIDTH = 8) → busy for 8 cycles; done at edge t+8; result = 0x8F; nzp = 100. Repeat with 16 × 16 → result 0x00, nzp = 010.
- LEA pc = 0x3E, imm = 0x05, PC_WIDTH = 6 → result = 0x03 (wrap), nzp = 001. Then NOT use_imm = 1, imm = 0x05 → result = 0xFA.
- Start during busy of a MUL with op = ADD and different operands → ignored; only the MUL completes, with exactly one done pulse. Inputs changed after acceptance do not alter the result.
- Assert rst at cycle 4 of a MUL → busy, done, result, nzp, illegal = 0, 0, 0x00, 010, 0 immediately; no done afterwards. A new ADD issued after release completes normally.
- op = 111 → done after 1 cycle with illegal = 1, result = 0, nzp = 010. The following valid AND (0xF0 & 0x3C = 0x30) clears illegal; nzp = 001.
